// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a small write FIFO in front of the framer.
// Frames are start, DATA_W bits LSB first, optional parity, STOP_BITS stop bits.
//
// state | meaning
// IDLE  | line high, waiting for tx_en and a queued word
// START | start bit (txd=0)
// DATA  | shifting data bits out, LSB first
// PAR   | parity bit (even or odd, computed when the word is popped)
// STOP  | stop bit(s); last one may chain straight into the next START
module uart_tx_param #(
   parameter int FCLK       = 50000000,
   parameter int BAUD       = 115200,
   parameter int DATA_W     = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_W-1:0]             dat,
   input  logic                          st,
   output logic                          rdy,
   input  logic                          tx_en,
   output logic                          txd,
   output logic                          ce,
   output logic                          busy,
   output logic                          ce_stop,
   output logic                          fifo_full,
   output logic                          fifo_empty,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int DIV       = FCLK / BAUD;
   localparam int CNT_W     = $clog2(DIV);
   localparam int AW        = $clog2(FIFO_DEPTH);
   localparam int BC_W      = 4;
   localparam int DIV_M1    = DIV - 1;
   localparam int DATA_M1   = DATA_W - 1;
   localparam int STOP_M1   = STOP_BITS - 1;

   localparam logic [CNT_W-1:0] CNT_LAST  = DIV_M1[CNT_W-1:0];
   localparam logic [BC_W-1:0]  DATA_LAST = DATA_M1[BC_W-1:0];
   localparam logic [BC_W-1:0]  STOP_LAST = STOP_M1[BC_W-1:0];
   localparam logic [AW:0]      LVL_FULL  = FIFO_DEPTH[AW:0];
   localparam logic             PAR_ODD   = (PARITY == 2);
   localparam logic             PAR_EN    = (PARITY != 0);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic                par_q, par_d;
   logic                txd_q, txd_d;

   logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]         level_q, level_d;
   logic [DATA_W-1:0]   rd_word;
   logic                push, pop, load, start_ok;

   // rdy comes only from the registered level, so a same-cycle pop never frees a slot
   assign fifo_full  = (level_q == LVL_FULL);
   assign fifo_empty = (level_q == '0);
   assign rdy        = !fifo_full;
   assign level      = level_q;
   assign push       = st && rdy;
   assign rd_word    = mem_q[rd_ptr_q];
   assign start_ok   = tx_en && !fifo_empty;

   assign txd     = txd_q;
   assign busy    = (state_q != IDLE);
   assign ce      = (state_q != IDLE) && (cnt_q == CNT_LAST);
   assign ce_stop = ce && (state_q == STOP) && (bit_cnt_q == STOP_LAST);

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      txd_d     = txd_q;
      load      = 1'b0;
      pop       = 1'b0;

      if (state_q != IDLE) begin
         cnt_d = ce ? '0 : cnt_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            load = start_ok;
         end
         START: begin
            if (ce) begin
               state_d   = DATA;
               bit_cnt_d = '0;
               txd_d     = shift_q[0];
            end
         end
         DATA: begin
            if (ce) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == DATA_LAST) begin
                  bit_cnt_d = '0;
                  if (PAR_EN) begin
                     state_d = PAR;
                     txd_d   = par_q;
                  end else begin
                     state_d = STOP;
                     txd_d   = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  txd_d     = shift_q[1];
               end
            end
         end
         PAR: begin
            if (ce) begin
               state_d   = STOP;
               bit_cnt_d = '0;
               txd_d     = 1'b1;
            end
         end
         STOP: begin
            if (ce_stop) begin
               load    = start_ok;
               state_d = IDLE;
               txd_d   = 1'b1;
            end else if (ce) begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            txd_d   = 1'b1;
         end
      endcase

      // Shared by IDLE and the last stop bit so back-to-back frames have no gap
      if (load) begin
         pop       = 1'b1;
         state_d   = START;
         cnt_d     = '0;
         bit_cnt_d = '0;
         shift_d   = rd_word;
         par_d     = (^rd_word) ^ PAR_ODD;
         txd_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         txd_q     <= 1'b1;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         txd_q     <= txd_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
      end
   end

   // Storage needs no reset; level and pointers define what is valid
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= dat;
      end
   end

endmodule
